// File: rtl/hoeraa_err_monitor.sv
// hoeraa_err_monitor: self-running error characterisation of one HOERAA
// approximate adder (N bits, K approximate low bits) against an exact adder.
// An LFSR supplies operand pairs; the error distance (ED) statistics are
// accumulated as error count, maximum ED and saturating summed ED.
//
// HOERAA model used here (bit i of operands x, y):
//   g          = x[K-2] & y[K-2]            (0 when K == 1)
//   S[K-1]     = (x[K-1] ^ y[K-1]) | g
//   S[K-2:0]   = (x | y)[K-2:0] | {g..g}
//   carry-in   = x[K-1] & y[K-1] into an exact (N-K)-bit upper adder
//
// Optional feature: define HOERAA_MON_BIAS_EN to add the signed,
// saturating err_bias output (sum of {Co,S} - exact).
//
// Issue timing: the first sample is issued on the accepted start edge, so a
// run of n samples keeps busy high for n+2 cycles and raises done exactly
// 3 cycles after the last issue.

module hoeraa_err_monitor #(
  parameter int unsigned N     = 16,
  parameter int unsigned K     = 10,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic [31:0]        seed,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   err_count,
  output logic [N:0]         max_ed,
  output logic [ACC_W-1:0]   sum_ed
`ifdef HOERAA_MON_BIAS_EN
  ,
  output logic signed [ACC_W-1:0] err_bias
`endif
);

  localparam int unsigned AW = N + 1;                          // {Co,S} and ED width
  localparam int unsigned HW = N - K + 1;                      // exact upper part with carry-out
  localparam int unsigned SW = ((ACC_W > AW) ? ACC_W : AW) + 1; // headroom for sum_ed add
  localparam logic [31:0]    LFSR_TAPS = 32'h8020_0003;         // x^32+x^22+x^2+x+1, right shift
  localparam logic [N-1:0]   LO_MASK   = N'((32'd1 << (K - 1)) - 32'd1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  state_t            state;
  logic [31:0]       lfsr;
  logic [CNT_W-1:0]  remaining;
  logic [N-1:0]      s1_x;
  logic [N-1:0]      s1_y;
  logic              s1_v;
  logic [AW-1:0]     s2_ed;
  logic              s2_v;

  logic [31:0]       seed_eff_c;
  logic              g_c;
  logic              bk_c;
  logic              cy_c;
  logic [N-1:0]      lo_c;
  logic [HW-1:0]     hi_c;
  logic [AW-1:0]     approx_c;
  logic [AW-1:0]     exact_c;
  logic [AW-1:0]     ed_c;
  logic [SW-1:0]     sum_wide_c;
  logic [ACC_W-1:0]  sum_nxt_c;
  logic [CNT_W-1:0]  err_nxt_c;
  logic [AW-1:0]     max_nxt_c;

  // Error-reduction guard bit only exists when there are at least two approximate bits
  generate
    if (K >= 2) begin : g_guard
      assign g_c = s1_x[K-2] & s1_y[K-2];
    end else begin : g_noguard
      assign g_c = 1'b0;
    end
  endgenerate

  // HOERAA sum, exact sum and their absolute difference from the S1 operands
  always_comb begin
    seed_eff_c = (seed == 32'h0) ? 32'h0000_0001 : seed;
    bk_c       = (s1_x[K-1] ^ s1_y[K-1]) | g_c;
    cy_c       = s1_x[K-1] & s1_y[K-1];
    lo_c       = (s1_x | s1_y | {N{g_c}}) & LO_MASK;
    hi_c       = HW'(s1_x[N-1:K]) + HW'(s1_y[N-1:K]) + HW'(cy_c);
    approx_c   = (AW'(hi_c) << K) | (AW'(bk_c) << (K - 1)) | AW'(lo_c);
    exact_c    = AW'(s1_x) + AW'(s1_y);
    ed_c       = (approx_c >= exact_c) ? (approx_c - exact_c) : (exact_c - approx_c);
  end

  // Saturating next values for the ED statistics
  always_comb begin
    sum_wide_c = SW'(sum_ed) + SW'(s2_ed);
    sum_nxt_c  = (sum_wide_c > SW'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : sum_wide_c[ACC_W-1:0];
    err_nxt_c  = ((s2_ed != '0) && (err_count != {CNT_W{1'b1}})) ? (err_count + CNT_W'(1))
                                                                  : err_count;
    max_nxt_c  = (s2_ed > max_ed) ? s2_ed : max_ed;
  end

`ifdef HOERAA_MON_BIAS_EN
  localparam int unsigned BW = ((ACC_W > AW + 1) ? ACC_W : AW + 1) + 1;
  localparam logic signed [BW-1:0] B_MAX = BW'((64'd1 << (ACC_W - 1)) - 64'd1);
  localparam logic signed [BW-1:0] B_MIN = -B_MAX - $signed(BW'(1));

  logic signed [AW:0]       serr_c;
  logic signed [AW:0]       s2_err;
  logic signed [BW-1:0]     bias_wide_c;
  logic signed [ACC_W-1:0]  bias_nxt_c;

  // Signed error and its saturating accumulation
  always_comb begin
    serr_c      = $signed({1'b0, approx_c}) - $signed({1'b0, exact_c});
    bias_wide_c = BW'(err_bias) + BW'(s2_err);
    if (bias_wide_c > B_MAX)      bias_nxt_c = ACC_W'(B_MAX);
    else if (bias_wide_c < B_MIN) bias_nxt_c = ACC_W'(B_MIN);
    else                          bias_nxt_c = ACC_W'(bias_wide_c);
  end

  // Signed error pipeline stage and accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_err   <= '0;
      err_bias <= '0;
    end else begin
      if (s1_v) s2_err <= serr_c;
      if (s2_v) err_bias <= bias_nxt_c;
      if (start && ((state == ST_IDLE) || (state == ST_DONE))) err_bias <= '0;
    end
  end
`endif

  // Control FSM, operand issue, ED pipeline and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      lfsr      <= 32'h0000_0001;
      remaining <= '0;
      s1_x      <= '0;
      s1_y      <= '0;
      s1_v      <= 1'b0;
      s2_ed     <= '0;
      s2_v      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_count <= '0;
      max_ed    <= '0;
      sum_ed    <= '0;
    end else begin
      s1_v <= 1'b0;
      s2_v <= s1_v;
      if (s1_v) s2_ed <= ed_c;
      if (s2_v) begin
        err_count <= err_nxt_c;
        max_ed    <= max_nxt_c;
        sum_ed    <= sum_nxt_c;
      end
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            err_count <= '0;
            max_ed    <= '0;
            sum_ed    <= '0;
            done      <= 1'b0;
            if (num_samples == '0) begin
              lfsr  <= seed_eff_c;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              s1_x      <= seed_eff_c[N-1:0];
              s1_y      <= seed_eff_c[N+15:16];
              s1_v      <= 1'b1;
              lfsr      <= lfsr_step(seed_eff_c);
              remaining <= num_samples - CNT_W'(1);
              busy      <= 1'b1;
              state     <= (num_samples == CNT_W'(1)) ? ST_DRAIN : ST_RUN;
            end
          end
        end
        ST_RUN: begin
          s1_x      <= lfsr[N-1:0];
          s1_y      <= lfsr[N+15:16];
          s1_v      <= 1'b1;
          lfsr      <= lfsr_step(lfsr);
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!s1_v && !s2_v) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hoeraa_err_monitor.sv
// Bench for hoeraa_err_monitor: two instances share stimulus, one with the
// default 32-bit accumulator and one with a 4-bit accumulator for saturation.
// Expected statistics come from an arithmetic reference model of the LFSR,
// the HOERAA adder and the accumulation rules.

module tb_hoeraa_err_monitor;

  localparam int unsigned N     = 16;
  localparam int unsigned K     = 10;
  localparam int unsigned CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  num;
  logic [31:0]       seed;

  logic              busy_a, done_a, busy_b, done_b;
  logic [CNT_W-1:0]  err_a, err_b;
  logic [N:0]        max_a, max_b;
  logic [31:0]       sum_a;
  logic [3:0]        sum_b;
`ifdef HOERAA_MON_BIAS_EN
  logic signed [31:0] bias_a;
  logic signed [3:0]  bias_b;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hoeraa_err_monitor #(.N(N), .K(K), .CNT_W(CNT_W), .ACC_W(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num), .seed(seed),
    .busy(busy_a), .done(done_a), .err_count(err_a), .max_ed(max_a), .sum_ed(sum_a)
`ifdef HOERAA_MON_BIAS_EN
    , .err_bias(bias_a)
`endif
  );

  hoeraa_err_monitor #(.N(N), .K(K), .CNT_W(CNT_W), .ACC_W(4)) u_sat (
    .clk(clk), .rst(rst), .start(start), .num_samples(num), .seed(seed),
    .busy(busy_b), .done(done_b), .err_count(err_b), .max_ed(max_b), .sum_ed(sum_b)
`ifdef HOERAA_MON_BIAS_EN
    , .err_bias(bias_b)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Reference: run the LFSR and HOERAA arithmetically and accumulate ED stats
  task automatic model(input logic [31:0] sd, input int n, input int accw,
                       output longint e_cnt, output longint e_max,
                       output longint e_sum, output longint e_bias);
    logic [31:0] s;
    longint x, y, g, low, bk, c, hi, approx, exact, err, ed;
    longint smax, bmax, bmin;
    smax = (longint'(1) << accw) - 1;
    bmax = (longint'(1) << (accw - 1)) - 1;
    bmin = -(longint'(1) << (accw - 1));
    s = (sd == 32'h0) ? 32'h1 : sd;
    e_cnt = 0; e_max = 0; e_sum = 0; e_bias = 0;
    for (int i = 0; i < n; i++) begin
      x = longint'(s % 32'h1_0000);
      y = longint'(s / 32'h1_0000);
      g = ((x >> (K - 2)) & 1) * ((y >> (K - 2)) & 1);
      low = (g == 1) ? ((longint'(1) << (K - 1)) - 1) : ((x | y) % (longint'(1) << (K - 1)));
      bk = (((x >> (K - 1)) + (y >> (K - 1))) % 2) | g;
      c = ((x >> (K - 1)) & 1) * ((y >> (K - 1)) & 1);
      hi = (x >> K) + (y >> K) + c;
      approx = hi * (longint'(1) << K) + bk * (longint'(1) << (K - 1)) + low;
      exact = x + y;
      err = approx - exact;
      ed = (err < 0) ? -err : err;
      if (ed != 0 && e_cnt < 65535) e_cnt++;
      if (ed > e_max) e_max = ed;
      e_sum = (e_sum + ed > smax) ? smax : e_sum + ed;
      e_bias = e_bias + err;
      if (e_bias > bmax) e_bias = bmax;
      if (e_bias < bmin) e_bias = bmin;
      // Galois step: divide by x, fold x^32+x^22+x^2+x+1 back in when bit 0 was set
      if (s[0]) s = (s >> 1) ^ ((32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1);
      else      s = s >> 1;
    end
  endtask

  // One complete run: start, optional ignored mid-run start, timing and stat checks
  task automatic do_run(input string lbl, input int n, input logic [31:0] sd, input bit mid_start);
    int k, busy_cnt;
    bit got_done, wrap_seen;
    logic [3:0] prev_b;
    longint c_a, m_a, s_a, b_a, c_b, m_b, s_b, b_b;
    model(sd, n, 32, c_a, m_a, s_a, b_a);
    model(sd, n, 4, c_b, m_b, s_b, b_b);
    @(negedge clk);
    start = 1'b1; num = CNT_W'(n); seed = sd;
    @(negedge clk);
    start = 1'b0;
    k = 1; busy_cnt = 0; got_done = 1'b0; wrap_seen = 1'b0; prev_b = 4'd0;
    while (k <= n + 10) begin
      if (busy_a) busy_cnt++;
      if (sum_b < prev_b) wrap_seen = 1'b1;
      prev_b = sum_b;
      if (done_a) begin
        got_done = 1'b1;
        break;
      end
      if (mid_start && k == 50) begin
        start = 1'b1; num = CNT_W'(5); seed = 32'h0000_0123;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check_eq({lbl, "_done_seen"}, 64'(got_done), 64'(1));
    check_eq({lbl, "_done_lat"}, 64'(k), 64'((n == 0) ? 1 : n + 3));
    check_eq({lbl, "_busy_cycles"}, 64'(busy_cnt), 64'((n == 0) ? 0 : n + 2));
    check_eq({lbl, "_busy_at_done"}, 64'(busy_a), 64'(0));
    check_eq({lbl, "_err_count"}, 64'(err_a), 64'(c_a));
    check_eq({lbl, "_max_ed"}, 64'(max_a), 64'(m_a));
    check_eq({lbl, "_sum_ed"}, 64'(sum_a), 64'(s_a));
    check_eq({lbl, "_sat_done"}, 64'(done_b), 64'(1));
    check_eq({lbl, "_sat_sum_ed"}, 64'(sum_b), 64'(s_b));
    check_eq({lbl, "_sat_err_count"}, 64'(err_b), 64'(c_b));
    check_eq({lbl, "_sat_no_wrap"}, 64'(wrap_seen), 64'(0));
`ifdef HOERAA_MON_BIAS_EN
    check_eq({lbl, "_err_bias"}, 64'(longint'(bias_a)), 64'(b_a));
    check_eq({lbl, "_sat_err_bias"}, 64'(longint'(bias_b)), 64'(b_b));
`endif
    // Stats stay frozen in DONE
    repeat (3) @(negedge clk);
    check_eq({lbl, "_frozen_sum"}, 64'(sum_a), 64'(s_a));
    check_eq({lbl, "_done_held"}, 64'(done_a), 64'(1));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num = '0; seed = '0;
    #12;
    check_eq("rst_busy", 64'(busy_a), 64'(0));
    check_eq("rst_done", 64'(done_a), 64'(0));
    check_eq("rst_err_count", 64'(err_a), 64'(0));
    check_eq("rst_max_ed", 64'(max_a), 64'(0));
    check_eq("rst_sum_ed", 64'(sum_a), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Disjoint operands: exact sum, no error
    do_run("aa55", 1, 32'h00AA_0055, 1'b0);
    check_eq("aa55_sum_zero", 64'(sum_a), 64'(0));
    check_eq("aa55_max_zero", 64'(max_a), 64'(0));

    do_run("zero_n", 0, 32'h0000_1234, 1'b0);
    check_eq("zero_n_sum_zero", 64'(sum_a), 64'(0));

    do_run("seed0", 1, 32'h0000_0000, 1'b0);
    check_eq("seed0_err_zero", 64'(err_a), 64'(0));

    do_run("long", 1000, 32'hACE1_1234, 1'b1);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    start = 1'b1; num = CNT_W'(100); seed = 32'h5A5A_5A5A;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("mid_busy_pre", 64'(busy_a), 64'(1));
    #2 rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", 64'(busy_a), 64'(0));
    check_eq("mid_rst_done", 64'(done_a), 64'(0));
    check_eq("mid_rst_err_count", 64'(err_a), 64'(0));
    check_eq("mid_rst_max_ed", 64'(max_a), 64'(0));
    check_eq("mid_rst_sum_ed", 64'(sum_a), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    do_run("post_rst", 5, 32'h0BAD_F00D, 1'b0);

    // All-ones region: 4-bit accumulator must pin at 15
    do_run("sat", 200, 32'hFFFF_FFFF, 1'b0);
    check_eq("sat_pinned", 64'(sum_b), 64'(15));

    for (int r = 0; r < 4; r++) begin
      do_run($sformatf("rnd%0d", r), int'($urandom_range(1, 80)), 32'($urandom), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
